// File: rtl/writeback_arbiter_if.sv
// Result channels from the AluMisc, Mem and Mult units and the register-file/scoreboard
// write port. The arbiter uses the slave side; the functional units (or a bench) use master.
interface writeback_arbiter_if;
    logic        am_wb_valid;
    logic [4:0]  am_wb_regdest;
    logic [31:0] am_wb_data;
    logic        am_wb_writereg;
    logic        wb_am_ready;

    logic        mem_wb_valid;
    logic [4:0]  mem_wb_regdest;
    logic [31:0] mem_wb_data;
    logic        mem_wb_writereg;
    logic        wb_mem_ready;

    logic        mul_wb_valid;
    logic [4:0]  mul_wb_regdest;
    logic [31:0] mul_wb_data;
    logic        mul_wb_writereg;
    logic        wb_mul_ready;

    logic        wb_reg_writeenable;
    logic [4:0]  wb_reg_writeaddr;
    logic [31:0] wb_reg_writedata;
    logic        wb_sb_enablewrite;
    logic [4:0]  wb_sb_writeaddr;
    logic [1:0]  wb_sb_registerunit;
    logic        wb_busy;

    modport master (
        output am_wb_valid, am_wb_regdest, am_wb_data, am_wb_writereg,
        output mem_wb_valid, mem_wb_regdest, mem_wb_data, mem_wb_writereg,
        output mul_wb_valid, mul_wb_regdest, mul_wb_data, mul_wb_writereg,
        input  wb_am_ready, wb_mem_ready, wb_mul_ready,
        input  wb_reg_writeenable, wb_reg_writeaddr, wb_reg_writedata,
        input  wb_sb_enablewrite, wb_sb_writeaddr, wb_sb_registerunit, wb_busy
    );

    modport slave (
        input  am_wb_valid, am_wb_regdest, am_wb_data, am_wb_writereg,
        input  mem_wb_valid, mem_wb_regdest, mem_wb_data, mem_wb_writereg,
        input  mul_wb_valid, mul_wb_regdest, mul_wb_data, mul_wb_writereg,
        output wb_am_ready, wb_mem_ready, wb_mul_ready,
        output wb_reg_writeenable, wb_reg_writeaddr, wb_reg_writedata,
        output wb_sb_enablewrite, wb_sb_writeaddr, wb_sb_registerunit, wb_busy
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-unit result FIFOs arbitrated round-robin onto the single register-file write port,
// with a matching scoreboard release pulse for every write.
module writeback_arbiter #(
    parameter int DEPTH = 2,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic               clock,
    input  logic               reset,
    writeback_arbiter_if.slave wb,
    output logic [1:0]         dbg_rr_o
);
    // Handshake: a unit transfers when valid & ready at a rising edge; while valid is high
    // and ready low it holds its fields stable. Ready depends only on registered counts.
    typedef enum logic [1:0] {
        RR_AM  = 2'b00,
        RR_MEM = 2'b01,
        RR_MUL = 2'b10
    } rr_e;

    localparam int NU = 3;
    localparam int EW = 37;
    localparam logic [PTRW:0]   CNT_FULL = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   CNT_ONE  = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);

    logic [NU-1:0] in_valid;
    logic [NU-1:0] in_writereg;
    logic [4:0]    in_regdest [NU];
    logic [31:0]   in_data    [NU];

    logic [NU-1:0] ready;
    logic [NU-1:0] push;
    logic [NU-1:0] pop;
    logic [NU-1:0] nonempty;

    logic [EW-1:0]   fifo_q   [NU][DEPTH];
    logic [PTRW-1:0] wr_ptr_q [NU];
    logic [PTRW-1:0] rd_ptr_q [NU];
    logic [PTRW:0]   cnt_q    [NU];
    logic [PTRW:0]   cnt_d    [NU];

    rr_e           rr_q, rr_d;
    logic          grant_vld;
    logic [1:0]    grant_unit;
    logic [EW-1:0] head;
    logic          busy_d;

    logic        we_q;
    logic [4:0]  addr_q;
    logic [31:0] data_q;
    logic [1:0]  unit_q;
    logic        busy_q;

    always_comb begin
        in_valid       = {wb.mul_wb_valid, wb.mem_wb_valid, wb.am_wb_valid};
        in_writereg    = {wb.mul_wb_writereg, wb.mem_wb_writereg, wb.am_wb_writereg};
        in_regdest[0]  = wb.am_wb_regdest;
        in_regdest[1]  = wb.mem_wb_regdest;
        in_regdest[2]  = wb.mul_wb_regdest;
        in_data[0]     = wb.am_wb_data;
        in_data[1]     = wb.mem_wb_data;
        in_data[2]     = wb.mul_wb_data;
    end

    // Unit index k steps after u in AluMisc -> Mem -> Mult order.
    function automatic logic [1:0] rot(input logic [1:0] u, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, u} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    // Results that write no register are acknowledged but never stored.
    always_comb begin
        nonempty = '0;
        ready    = '0;
        push     = '0;
        for (int u = 0; u < NU; u++) begin
            nonempty[u] = (cnt_q[u] != '0);
            ready[u]    = (cnt_q[u] != CNT_FULL);
            push[u]     = in_valid[u] & ready[u] & in_writereg[u] & (in_regdest[u] != 5'd0);
        end
    end

    always_comb begin : arbitrate
        logic [1:0] cand;
        grant_vld  = 1'b0;
        grant_unit = rr_q;
        cand       = rr_q;
        for (int k = 0; k < NU; k++) begin
            cand = rot(rr_q, 2'(k));
            if (!grant_vld && nonempty[cand]) begin
                grant_vld  = 1'b1;
                grant_unit = cand;
            end
        end
        rr_d = grant_vld ? rr_e'(rot(grant_unit, 2'd1)) : rr_q;
        pop  = '0;
        if (grant_vld) pop[grant_unit] = 1'b1;
        head = fifo_q[grant_unit][rd_ptr_q[grant_unit]];
    end

    always_comb begin
        busy_d = 1'b0;
        for (int u = 0; u < NU; u++) begin
            cnt_d[u] = cnt_q[u];
            if (push[u] && !pop[u]) begin
                cnt_d[u] = cnt_q[u] + CNT_ONE;
            end else if (!push[u] && pop[u]) begin
                cnt_d[u] = cnt_q[u] - CNT_ONE;
            end
            busy_d = busy_d | (cnt_d[u] != '0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q   <= RR_AM;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            unit_q <= '0;
            busy_q <= 1'b0;
            for (int u = 0; u < NU; u++) begin
                wr_ptr_q[u] <= '0;
                rd_ptr_q[u] <= '0;
                cnt_q[u]    <= '0;
            end
        end else begin
            rr_q   <= rr_d;
            we_q   <= grant_vld;
            busy_q <= busy_d;
            if (grant_vld) begin
                addr_q <= head[36:32];
                data_q <= head[31:0];
                unit_q <= grant_unit;
            end
            for (int u = 0; u < NU; u++) begin
                cnt_q[u] <= cnt_d[u];
                if (push[u]) wr_ptr_q[u] <= wr_ptr_q[u] + PTR_ONE;
                if (pop[u])  rd_ptr_q[u] <= rd_ptr_q[u] + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: occupancy is tracked entirely by the counts.
    always_ff @(posedge clock) begin
        for (int u = 0; u < NU; u++) begin
            if (push[u]) fifo_q[u][wr_ptr_q[u]] <= {in_regdest[u], in_data[u]};
        end
    end

    assign wb.wb_am_ready        = ready[0];
    assign wb.wb_mem_ready       = ready[1];
    assign wb.wb_mul_ready       = ready[2];
    assign wb.wb_reg_writeenable = we_q;
    assign wb.wb_reg_writeaddr   = addr_q;
    assign wb.wb_reg_writedata   = data_q;
    assign wb.wb_sb_enablewrite  = we_q;
    assign wb.wb_sb_writeaddr    = addr_q;
    assign wb.wb_sb_registerunit = unit_q;
    assign wb.wb_busy            = busy_q;
    assign dbg_rr_o              = rr_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued in hand-computed grant
// order when stimulus is issued; a negedge monitor pops and compares every write it sees.
module tb_writeback_arbiter;
    logic       clock;
    logic       reset;
    logic [1:0] dbg_rr;

    writeback_arbiter_if wb ();

    writeback_arbiter #(.DEPTH(2), .PTRW(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .wb       (wb),
        .dbg_rr_o (dbg_rr)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [38:0] exp_q[$];
    logic [38:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [38:0] ent(input logic [1:0] unit, input logic [4:0] rd,
                                        input logic [31:0] d);
        return {unit, rd, d};
    endfunction

    // Driver tasks
    task automatic set_unit(input int u, input logic v, input logic [4:0] rd,
                            input logic [31:0] d, input logic wr);
        case (u)
            0: begin
                wb.am_wb_valid = v; wb.am_wb_regdest = rd;
                wb.am_wb_data = d; wb.am_wb_writereg = wr;
            end
            1: begin
                wb.mem_wb_valid = v; wb.mem_wb_regdest = rd;
                wb.mem_wb_data = d; wb.mem_wb_writereg = wr;
            end
            default: begin
                wb.mul_wb_valid = v; wb.mul_wb_regdest = rd;
                wb.mul_wb_data = d; wb.mul_wb_writereg = wr;
            end
        endcase
    endtask

    function automatic logic get_ready(input int u);
        case (u)
            0:       return wb.wb_am_ready;
            1:       return wb.wb_mem_ready;
            default: return wb.wb_mul_ready;
        endcase
    endfunction

    // Holds valid until the unit's ready is seen at an edge, then drops it.
    task automatic drive_unit(input int u, input logic [4:0] rd, input logic [31:0] d,
                              input logic wr);
        bit done;
        done = 1'b0;
        set_unit(u, 1'b1, rd, d, wr);
        for (int i = 0; i < 40 && !done; i++) begin
            if (get_ready(u)) done = 1'b1;
            tick();
        end
        set_unit(u, 1'b0, 5'd0, 32'd0, 1'b0);
        check($sformatf("accept_u%0d_r%0d", u, rd), 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (2) tick();
    endtask

    // Scoreboard monitor
    always @(negedge clock) begin
        if (mon_en && (wb.wb_reg_writeenable || wb.wb_sb_enablewrite)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {27'd0, wb.wb_sb_registerunit, wb.wb_reg_writeaddr,
                      wb.wb_reg_writedata}, 64'h0);
            end else begin
                mon_e = exp_q.pop_front();
                check("strobe_pair", {63'd0, wb.wb_sb_enablewrite}, {63'd0, wb.wb_reg_writeenable});
                check("reg_addr", 64'(wb.wb_reg_writeaddr), 64'(mon_e[36:32]));
                check("sb_addr", 64'(wb.wb_sb_writeaddr), 64'(mon_e[36:32]));
                check("reg_data", 64'(wb.wb_reg_writedata), 64'(mon_e[31:0]));
                check("sb_unit", 64'(wb.wb_sb_registerunit), 64'(mon_e[38:37]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        for (int u = 0; u < 3; u++) set_unit(u, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        tick();
        check("rst_we", 64'(wb.wb_reg_writeenable), 64'd0);
        check("rst_sbe", 64'(wb.wb_sb_enablewrite), 64'd0);
        check("rst_addr", 64'(wb.wb_reg_writeaddr), 64'd0);
        check("rst_data", 64'(wb.wb_reg_writedata), 64'd0);
        check("rst_sb_addr", 64'(wb.wb_sb_writeaddr), 64'd0);
        check("rst_unit", 64'(wb.wb_sb_registerunit), 64'd0);
        check("rst_busy", 64'(wb.wb_busy), 64'd0);
        check("rst_rr", 64'(dbg_rr), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst_ready", {61'd0, wb.wb_mul_ready, wb.wb_mem_ready, wb.wb_am_ready}, 64'h7);

        // Load all queues, then reset mid-operation: everything queued is discarded.
        set_unit(0, 1'b1, 5'd10, 32'h1010, 1'b1);
        set_unit(1, 1'b1, 5'd11, 32'h1111, 1'b1);
        set_unit(2, 1'b1, 5'd12, 32'h1212, 1'b1);
        tick();
        tick();
        for (int u = 0; u < 3; u++) set_unit(u, 1'b0, 5'd0, 32'd0, 1'b0);
        reset = 1'b1;
        tick();
        mon_en = 1'b1;
        reset = 1'b0;
        tick();
        check("mid_rst_we", 64'(wb.wb_reg_writeenable), 64'd0);
        check("mid_rst_sbe", 64'(wb.wb_sb_enablewrite), 64'd0);
        check("mid_rst_busy", 64'(wb.wb_busy), 64'd0);
        check("mid_rst_ready", {61'd0, wb.wb_mul_ready, wb.wb_mem_ready, wb.wb_am_ready}, 64'h7);
        repeat (3) tick();

        // Single AluMisc result: strobe exactly one cycle, one cycle after acceptance.
        exp_q.push_back(ent(2'b00, 5'd5, 32'hDEADBEEF));
        set_unit(0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
        check("single_ready", 64'(wb.wb_am_ready), 64'd1);
        tick();
        set_unit(0, 1'b0, 5'd0, 32'd0, 1'b0);
        check("single_n_we", 64'(wb.wb_reg_writeenable), 64'd0);
        check("single_n_busy", 64'(wb.wb_busy), 64'd1);
        tick();
        check("single_n1_we", 64'(wb.wb_reg_writeenable), 64'd1);
        check("single_n1_sbe", 64'(wb.wb_sb_enablewrite), 64'd1);
        tick();
        check("single_n2_we", 64'(wb.wb_reg_writeenable), 64'd0);
        check("single_n2_sbe", 64'(wb.wb_sb_enablewrite), 64'd0);
        check("single_n2_busy", 64'(wb.wb_busy), 64'd0);
        drain();

        // A Mult write moves the pointer back to AluMisc.
        exp_q.push_back(ent(2'b10, 5'd9, 32'h0000900D));
        drive_unit(2, 5'd9, 32'h0000900D, 1'b1);
        drain();
        check("rr_before_triple", 64'(dbg_rr), 64'd0);

        // Two simultaneous triples, each written am, mem, mul on consecutive cycles.
        for (int t = 0; t < 2; t++) begin
            for (int u = 0; u < 3; u++) begin
                exp_q.push_back(ent(2'(u), 5'(3 * t + u + 1), 32'(32'h100 * (3 * t + u + 1))));
                set_unit(u, 1'b1, 5'(3 * t + u + 1), 32'(32'h100 * (3 * t + u + 1)), 1'b1);
            end
            tick();
            for (int u = 0; u < 3; u++) set_unit(u, 1'b0, 5'd0, 32'd0, 1'b0);
            for (int c = 0; c < 3; c++) begin
                tick();
                check($sformatf("triple%0d_we_c%0d", t, c), 64'(wb.wb_reg_writeenable), 64'd1);
            end
            tick();
            check($sformatf("triple%0d_idle", t), 64'(wb.wb_reg_writeenable), 64'd0);
            drain();
        end

        // Mult back-to-back beyond DEPTH while AluMisc streams: grants alternate.
        exp_q.push_back(ent(2'b00, 5'd20, 32'hA0000001));
        exp_q.push_back(ent(2'b10, 5'd24, 32'hC0000001));
        exp_q.push_back(ent(2'b00, 5'd21, 32'hA0000002));
        exp_q.push_back(ent(2'b10, 5'd25, 32'hC0000002));
        exp_q.push_back(ent(2'b00, 5'd22, 32'hA0000003));
        exp_q.push_back(ent(2'b10, 5'd26, 32'hC0000003));
        exp_q.push_back(ent(2'b00, 5'd23, 32'hA0000004));
        fork
            begin
                for (int i = 0; i < 4; i++) drive_unit(0, 5'(20 + i), 32'hA0000001 + 32'(i), 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) drive_unit(2, 5'(24 + i), 32'hC0000001 + 32'(i), 1'b1);
            end
            begin
                tick();
                check("mul_ready_e0", 64'(wb.wb_mul_ready), 64'd1);
                tick();
                check("mul_ready_e1", 64'(wb.wb_mul_ready), 64'd0);
                tick();
                check("mul_ready_e2", 64'(wb.wb_mul_ready), 64'd1);
                check("am_ready_e2", 64'(wb.wb_am_ready), 64'd0);
            end
        join
        drain();

        // Filtered transfers: accepted, never written, never make the arbiter busy.
        drive_unit(0, 5'd7, 32'h00000077, 1'b0);
        check("filter_wr0_busy", 64'(wb.wb_busy), 64'd0);
        drive_unit(1, 5'd0, 32'h00000088, 1'b1);
        check("filter_r0_busy", 64'(wb.wb_busy), 64'd0);
        repeat (3) tick();
        check("filter_busy_late", 64'(wb.wb_busy), 64'd0);
        check("rr_before_full", 64'(dbg_rr), 64'd1);

        // AluMisc and Mem streams: queues fill, pop while full, pointers wrap over 12 entries.
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(ent(2'b01, 5'(8 + i), 32'hB0000000 + 32'(i)));
            exp_q.push_back(ent(2'b00, 5'(1 + i), 32'h50000000 + 32'(i)));
        end
        fork
            begin
                for (int i = 0; i < 6; i++) drive_unit(0, 5'(1 + i), 32'h50000000 + 32'(i), 1'b1);
            end
            begin
                for (int i = 0; i < 6; i++) drive_unit(1, 5'(8 + i), 32'hB0000000 + 32'(i), 1'b1);
            end
            begin
                tick();
                tick();
                tick();
                check("mem_full_pop_ready", 64'(wb.wb_mem_ready), 64'd0);
                tick();
                check("mem_after_pop_ready", 64'(wb.wb_mem_ready), 64'd1);
                check("am_full_ready", 64'(wb.wb_am_ready), 64'd0);
                tick();
                check("mem_refull_ready", 64'(wb.wb_mem_ready), 64'd0);
            end
        join
        drain();

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("final_busy", 64'(wb.wb_busy), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
